// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer slice.
package timer_pkg;

  localparam int unsigned HOURS_W = 4;
  localparam int unsigned MINS_W  = 6;
  localparam logic [MINS_W-1:0] MINS_MAX = 6'd59;

  typedef enum logic [2:0] {
    IDLE,
    SET_H,
    SET_M,
    RUN,
    PAUSE,
    ALARM
  } timer_state_t;

endpackage

// File: rtl/timer_tick_gen.sv
// Wrapping prescaler: counts 0..last_i while enabled and not held, ticks on wrap.
// Shared between the minute prescaler and the alarm duration count.
module timer_tick_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             hold_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             at_last;

  assign at_last = (cnt_q == last_i);
  assign tick_o  = enable_i && !hold_i && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !hold_i) begin
      cnt_q <= at_last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Countdown timer control FSM with hours/minutes value registers.
// Optional edit-field blinking is built when TIMER_BLINK_EN is defined.
module timer_ctrl_fsm
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 32'd3000000000,
  parameter int unsigned MAX_HOURS     = 12,
  parameter int unsigned ALARM_CYCLES  = 500000000,
  parameter int unsigned BLINK_CYCLES  = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_p,
  input  logic               inc_p,
  input  logic               start_stop_p,
  output logic [HOURS_W-1:0] hours_cur,
  output logic [MINS_W-1:0]  mins_cur,
  output logic               running,
  output logic               alarm,
  output logic               blank_hours,
  output logic               blank_mins
);

  localparam int unsigned CNT_SPAN = (TICKS_PER_MIN > ALARM_CYCLES) ? TICKS_PER_MIN : ALARM_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_SPAN);
  localparam logic [CNT_W-1:0]   TICK_LAST  = CNT_W'(TICKS_PER_MIN - 1);
  localparam logic [CNT_W-1:0]   ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);
  localparam logic [HOURS_W-1:0] HOURS_MAX  = HOURS_W'(MAX_HOURS);

  if (TICKS_PER_MIN < 2 || MAX_HOURS < 1 || MAX_HOURS > 15 ||
      ALARM_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
    $error("timer_ctrl_fsm: parameter out of range");
  end

  timer_state_t       state_q;
  logic [HOURS_W-1:0] hours_q;
  logic [MINS_W-1:0]  mins_q;
  logic               running_q;
  logic               alarm_q;

  logic               any_pulse;
  logic               cnt_enable;
  logic               cnt_hold;
  logic               cnt_clear;
  logic [CNT_W-1:0]   cnt_last;
  logic               tick;

  assign any_pulse  = start_stop_p || mode_p || inc_p;
  assign cnt_enable = (state_q == RUN) || (state_q == PAUSE) || (state_q == ALARM);
  assign cnt_hold   = (state_q == PAUSE);
  // Entry to RUN/ALARM needs no explicit clear: IDLE holds the counter at 0 and
  // RUN->ALARM only happens on a tick, where the counter wraps to 0 anyway.
  assign cnt_clear  = !cnt_enable ||
                      ((state_q == PAUSE) && mode_p && !start_stop_p) ||
                      ((state_q == ALARM) && any_pulse);
  assign cnt_last   = (state_q == ALARM) ? ALARM_LAST : TICK_LAST;

  timer_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear),
    .hold_i  (cnt_hold),
    .enable_i(cnt_enable),
    .last_i  (cnt_last),
    .tick_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hours_q   <= '0;
      mins_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_stop_p) begin
            if (hours_q != '0 || mins_q != '0) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end else if (mode_p) begin
            state_q <= SET_H;
          end
        end
        SET_H: begin
          if (start_stop_p) begin
            state_q <= IDLE;
          end else if (mode_p) begin
            state_q <= SET_M;
          end else if (inc_p) begin
            hours_q <= (hours_q == HOURS_MAX) ? '0 : hours_q + 1'b1;
          end
        end
        SET_M: begin
          if (start_stop_p || mode_p) begin
            state_q <= IDLE;
          end else if (inc_p) begin
            mins_q <= (mins_q == MINS_MAX) ? '0 : mins_q + 1'b1;
          end
        end
        RUN: begin
          if (start_stop_p) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (tick) begin
            if (mins_q != '0) begin
              mins_q <= mins_q - 1'b1;
              if (mins_q == 6'd1 && hours_q == '0) begin
                state_q   <= ALARM;
                running_q <= 1'b0;
                alarm_q   <= 1'b1;
              end
            end else if (hours_q != '0) begin
              mins_q  <= MINS_MAX;
              hours_q <= hours_q - 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start_stop_p) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (mode_p) begin
            state_q <= IDLE;
          end
        end
        ALARM: begin
          if (any_pulse || tick) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          alarm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign hours_cur = hours_q;
  assign mins_cur  = mins_q;
  assign running   = running_q;
  assign alarm     = alarm_q;

`ifdef TIMER_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blank_h_q;
  logic               blank_m_q;

  // Staying in an edit state means neither start_stop_p nor mode_p this cycle;
  // any other case (including entry and exit) restarts the phase as visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blank_h_q   <= 1'b0;
      blank_m_q   <= 1'b0;
    end else if ((state_q == SET_H || state_q == SET_M) && !start_stop_p && !mode_p) begin
      if (inc_p) begin
        blink_cnt_q <= '0;
        blank_h_q   <= 1'b0;
        blank_m_q   <= 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        if (state_q == SET_H) begin
          blank_h_q <= !blank_h_q;
        end else begin
          blank_m_q <= !blank_m_q;
        end
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_q <= '0;
      blank_h_q   <= 1'b0;
      blank_m_q   <= 1'b0;
    end
  end

  assign blank_hours = blank_h_q;
  assign blank_mins  = blank_m_q;
`else
  assign blank_hours = 1'b0;
  assign blank_mins  = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Self-checking bench for timer_ctrl_fsm against a value-level reference model.
module tb_timer_ctrl_fsm;

  localparam int unsigned TPM  = 4;
  localparam int unsigned MAXH = 12;
  localparam int unsigned ACYC = 6;
  localparam int unsigned BCYC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_p = 1'b0;
  logic       inc_p = 1'b0;
  logic       start_stop_p = 1'b0;
  logic [3:0] hours_cur;
  logic [5:0] mins_cur;
  logic       running;
  logic       alarm;
  logic       blank_hours;
  logic       blank_mins;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  timer_ctrl_fsm #(
    .TICKS_PER_MIN(TPM),
    .MAX_HOURS    (MAXH),
    .ALARM_CYCLES (ACYC),
    .BLINK_CYCLES (BCYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_p      (mode_p),
    .inc_p       (inc_p),
    .start_stop_p(start_stop_p),
    .hours_cur   (hours_cur),
    .mins_cur    (mins_cur),
    .running     (running),
    .alarm       (alarm),
    .blank_hours (blank_hours),
    .blank_mins  (blank_mins)
  );

  always #5 clk = ~clk;

  logic [13:0] dut_vec;
  assign dut_vec = {hours_cur, mins_cur, running, alarm, blank_hours, blank_mins};

  // Reference model: the timer value is a single count of minutes.
  typedef enum int {M_IDLE, M_SETH, M_SETM, M_RUN, M_PAUSE, M_ALARM} mstate_t;
  mstate_t m_st  = M_IDLE;
  int      m_total = 0;
  int      m_pre   = 0;
  int      m_bcnt  = 0;
  bit      m_bph   = 1'b0;

  always @(posedge clk) begin : ref_model
    mstate_t st;
    int total, pre, bcnt;
    bit bph, restart, tk;
    st = m_st; total = m_total; pre = m_pre; bcnt = m_bcnt; bph = m_bph;
    restart = 1'b0;
    if (!rst_n) begin
      st = M_IDLE; total = 0; pre = 0; bcnt = 0; bph = 1'b0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (start_stop_p) begin
            if (total != 0) st = M_RUN;
          end else if (mode_p) st = M_SETH;
        end
        M_SETH: begin
          if (start_stop_p) st = M_IDLE;
          else if (mode_p) st = M_SETM;
          else if (inc_p) begin
            total = (((total / 60) + 1) % (MAXH + 1)) * 60 + (total % 60);
            restart = 1'b1;
          end
        end
        M_SETM: begin
          if (start_stop_p || mode_p) st = M_IDLE;
          else if (inc_p) begin
            total = (total / 60) * 60 + ((total % 60) + 1) % 60;
            restart = 1'b1;
          end
        end
        M_RUN: begin
          tk  = (pre == TPM - 1);
          pre = tk ? 0 : pre + 1;
          if (start_stop_p) st = M_PAUSE;
          else if (tk) begin
            total = total - 1;
            if (total == 0) st = M_ALARM;
          end
        end
        M_PAUSE: begin
          if (start_stop_p) st = M_RUN;
          else if (mode_p) st = M_IDLE;
        end
        M_ALARM: begin
          if (start_stop_p || mode_p || inc_p || pre == ACYC - 1) st = M_IDLE;
          else pre = pre + 1;
        end
        default: st = M_IDLE;
      endcase
      if (st != M_RUN && st != M_PAUSE && st != M_ALARM) pre = 0;
      if (st == M_SETH || st == M_SETM) begin
        if (st != m_st || restart) begin
          bcnt = 0; bph = 1'b0;
        end else begin
          bcnt = bcnt + 1;
          if (bcnt == BCYC) begin
            bcnt = 0; bph = !bph;
          end
        end
      end else begin
        bcnt = 0; bph = 1'b0;
      end
    end
    m_st <= st; m_total <= total; m_pre <= pre; m_bcnt <= bcnt; m_bph <= bph;
  end

  function automatic logic [13:0] exp_vec();
    logic bh, bm;
    bh = 1'b0;
    bm = 1'b0;
`ifdef TIMER_BLINK_EN
    bh = (m_st == M_SETH) && m_bph;
    bm = (m_st == M_SETM) && m_bph;
`endif
    return {4'(m_total / 60), 6'(m_total % 60), m_st == M_RUN, m_st == M_ALARM, bh, bm};
  endfunction

  task automatic cyc(input bit ss, input bit md, input bit inc);
    start_stop_p = ss;
    mode_p       = md;
    inc_p        = inc;
    @(posedge clk);
    #1;
    start_stop_p = 1'b0;
    mode_p       = 1'b0;
    inc_p        = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    cyc(0, 0, 0);
    rst_n = 1'b1;
  endtask

  // From IDLE: enter SET_H, h increments, SET_M, m increments, back to IDLE.
  task automatic set_value(input int h, input int m);
    cyc(0, 1, 0);
    for (int i = 0; i < h; i++) cyc(0, 0, 1);
    cyc(0, 1, 0);
    for (int i = 0; i < m; i++) cyc(0, 0, 1);
    cyc(0, 1, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0);
    n_checks++;
    if (dut_vec !== 14'h0) begin
      $display("FAIL reset_values: got %h required %h", dut_vec, 14'h0); n_fail++;
    end
    cyc(1, 1, 1);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    n_checks++;
    if (dut_vec !== 14'h0) begin
      $display("FAIL reset_no_memory: got %h required %h", dut_vec, 14'h0); n_fail++;
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL reset_model: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
  endtask

  task automatic test_setup();
    reset_dut();
    set_value(3, 2);
    n_checks++;
    if (hours_cur !== 4'd3 || mins_cur !== 6'd2 || running !== 1'b0) begin
      $display("FAIL setup_value: got %0d:%0d run=%b required 3:2 run=0", hours_cur, mins_cur, running); n_fail++;
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL setup_model: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
    cyc(0, 0, 1);
    n_checks++;
    if (hours_cur !== 4'd3 || mins_cur !== 6'd2) begin
      $display("FAIL idle_inc_ignored: got %0d:%0d required 3:2", hours_cur, mins_cur); n_fail++;
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    cyc(0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1);
    n_checks++;
    if (hours_cur !== 4'd12) begin
      $display("FAIL hours_max: got %0d required 12", hours_cur); n_fail++;
    end
    cyc(0, 0, 1);
    n_checks++;
    if (hours_cur !== 4'd0) begin
      $display("FAIL hours_wrap: got %0d required 0", hours_cur); n_fail++;
    end
    cyc(0, 1, 0);
    for (int i = 0; i < 59; i++) cyc(0, 0, 1);
    n_checks++;
    if (mins_cur !== 6'd59) begin
      $display("FAIL mins_max: got %0d required 59", mins_cur); n_fail++;
    end
    cyc(0, 0, 1);
    n_checks++;
    if (mins_cur !== 6'd0) begin
      $display("FAIL mins_wrap: got %0d required 0", mins_cur); n_fail++;
    end
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    n_checks++;
    if (running !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL zero_start_ignored: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
  endtask

  task automatic test_countdown();
    int  k;
    bit  seen;
    reset_dut();
    set_value(1, 0);
    cyc(1, 0, 0);
    n_checks++;
    if (running !== 1'b1) begin
      $display("FAIL run_entry: got running=%b required 1", running); n_fail++;
    end
    repeat (3) cyc(0, 0, 0);
    n_checks++;
    if (hours_cur !== 4'd1 || mins_cur !== 6'd0) begin
      $display("FAIL pre_tick_hold: got %0d:%0d required 1:0", hours_cur, mins_cur); n_fail++;
    end
    cyc(0, 0, 0);
    n_checks++;
    if (hours_cur !== 4'd0 || mins_cur !== 6'd59 || running !== 1'b1) begin
      $display("FAIL borrow: got %0d:%0d run=%b required 0:59 run=1", hours_cur, mins_cur, running); n_fail++;
    end
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= 300 && !seen; i++) begin
      cyc(0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL countdown_model: cycle %0d got %h required %h", i, dut_vec, exp_vec()); n_fail++;
      end
      if (alarm === 1'b1) begin
        seen = 1'b1;
        k = i;
      end
    end
    n_checks++;
    if (!seen || k != 59 * TPM) begin
      $display("FAIL alarm_entry: alarm after %0d cycles (seen=%b) required %0d", k, seen, 59 * TPM); n_fail++;
    end
    n_checks++;
    if (hours_cur !== 4'd0 || mins_cur !== 6'd0 || running !== 1'b0) begin
      $display("FAIL alarm_value: got %0d:%0d run=%b required 0:0 run=0", hours_cur, mins_cur, running); n_fail++;
    end
    repeat (ACYC - 1) cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1) begin
      $display("FAIL alarm_hold: got alarm=%b required 1", alarm); n_fail++;
    end
    cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL alarm_autoclear: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
  endtask

  task automatic test_pause();
    reset_dut();
    set_value(0, 3);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0);
      n_checks++;
      if (mins_cur !== 6'd3 || running !== 1'b0) begin
        $display("FAIL pause_hold: cycle %0d got %0d run=%b required 3 run=0", i, mins_cur, running); n_fail++;
      end
    end
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    n_checks++;
    if (mins_cur !== 6'd3 || running !== 1'b1) begin
      $display("FAIL resume_early: got %0d run=%b required 3 run=1", mins_cur, running); n_fail++;
    end
    cyc(0, 0, 0);
    n_checks++;
    if (mins_cur !== 6'd2) begin
      $display("FAIL resume_tick: got %0d required 2", mins_cur); n_fail++;
    end
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    n_checks++;
    if (running !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL pause_to_idle: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    n_checks++;
    if (mins_cur !== 6'd2) begin
      $display("FAIL prescaler_cleared: got %0d required 2", mins_cur); n_fail++;
    end
    cyc(0, 0, 0);
    n_checks++;
    if (mins_cur !== 6'd1) begin
      $display("FAIL restart_tick: got %0d required 1", mins_cur); n_fail++;
    end
  endtask

  task automatic test_alarm_pulse();
    reset_dut();
    set_value(0, 1);
    cyc(1, 0, 0);
    repeat (TPM) cyc(0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1) begin
      $display("FAIL alarm_repeat: got alarm=%b required 1", alarm); n_fail++;
    end
    cyc(0, 0, 1);
    n_checks++;
    if (alarm !== 1'b0 || running !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL alarm_inc_exit: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
    set_value(0, 2);
    cyc(1, 0, 0);
    repeat (TPM - 1) cyc(0, 0, 0);
    cyc(1, 0, 0);
    n_checks++;
    if (mins_cur !== 6'd2 || running !== 1'b0) begin
      $display("FAIL stop_beats_tick: got %0d run=%b required 2 run=0", mins_cur, running); n_fail++;
    end
    cyc(1, 0, 0);
    for (int i = 0; i < 2 * TPM; i++) begin
      cyc(0, (i % 3) == 0, (i % 2) == 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL run_ignores_mode_inc: cycle %0d got %h required %h", i, dut_vec, exp_vec()); n_fail++;
      end
    end
  endtask

  task automatic test_priority();
    reset_dut();
    set_value(0, 5);
    cyc(1, 1, 0);
    n_checks++;
    if (running !== 1'b1 || mins_cur !== 6'd5) begin
      $display("FAIL ss_over_mode: got run=%b mins=%0d required run=1 mins=5", running, mins_cur); n_fail++;
    end
    cyc(0, 0, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0);
    n_checks++;
    if (dut_vec !== 14'h0) begin
      $display("FAIL reset_mid_run: got %h required %h", dut_vec, 14'h0); n_fail++;
    end
    rst_n = 1'b1;
    cyc(0, 1, 0);
    cyc(1, 0, 1);
    n_checks++;
    if (hours_cur !== 4'd0 || dut_vec !== exp_vec()) begin
      $display("FAIL ss_over_inc: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
  endtask

  task automatic test_blink();
    logic exp_b;
    reset_dut();
    cyc(0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc(0, 0, 0);
      exp_b = 1'b0;
`ifdef TIMER_BLINK_EN
      exp_b = ((k / BCYC) % 2) == 1;
`endif
      n_checks++;
      if (blank_hours !== exp_b || blank_mins !== 1'b0) begin
        $display("FAIL blink_hours: cycle %0d got %b/%b required %b/0", k, blank_hours, blank_mins, exp_b); n_fail++;
      end
    end
    cyc(0, 0, 1);
    n_checks++;
    if (blank_hours !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL blink_inc_restart: got %h required %h", dut_vec, exp_vec()); n_fail++;
    end
    cyc(0, 1, 0);
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL blink_mins: cycle %0d got %h required %h", k, dut_vec, exp_vec()); n_fail++;
      end
    end
    cyc(1, 0, 0);
    n_checks++;
    if (blank_hours !== 1'b0 || blank_mins !== 1'b0) begin
      $display("FAIL blink_exit: got %b/%b required 0/0", blank_hours, blank_mins); n_fail++;
    end
  endtask

  task automatic test_random();
    int r;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      rst_n = ($urandom_range(0, 499) != 0);
      cyc(r < 4, r >= 4 && r < 10, r >= 10 && r < 30);
      rst_n = 1'b1;
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL random: cycle %0d got %h required %h", i, dut_vec, exp_vec()); n_fail++;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_setup();
    test_wrap();
    test_countdown();
    test_pause();
    test_alarm_pulse();
    test_priority();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
